// File: rtl/upw_in_conditioner_if.sv
// Pad-input conditioning bus: raw pad inputs and bypass in, debounced level and edge pulses out.
interface upw_in_conditioner_if #(
  parameter int NUM_INS = 3
);
  logic [NUM_INS-1:0] io_in;
  logic               db_bypass;
  logic [NUM_INS-1:0] in_level;
  logic [NUM_INS-1:0] in_rise;
  logic [NUM_INS-1:0] in_fall;

  modport master (
    output io_in,
    output db_bypass,
    input  in_level,
    input  in_rise,
    input  in_fall
  );

  modport slave (
    input  io_in,
    input  db_bypass,
    output in_level,
    output in_rise,
    output in_fall
  );
endinterface

// File: rtl/upw_in_conditioner.sv
// Per-pad 2-flop synchronizer and debounce FSM producing a registered stable level
// with one-cycle rise/fall pulses for the counter control logic.
module upw_in_conditioner #(
  parameter int NUM_INS         = 3,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  upw_in_conditioner_if.slave  bus
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // state     | meaning
  // STABLE_LO | accepted low; CHK_HI counting high samples; STABLE_HI / CHK_LO mirror
  typedef enum logic [1:0] {STABLE_LO, CHK_HI, STABLE_HI, CHK_LO} state_t;

  state_t             state_q [NUM_INS];
  state_t             state_d [NUM_INS];
  logic [CNT_W-1:0]   cnt_q   [NUM_INS];
  logic [CNT_W-1:0]   cnt_d   [NUM_INS];
  logic [NUM_INS-1:0] s1, s2;
  logic [NUM_INS-1:0] level_q, rise_q, fall_q;
  logic [NUM_INS-1:0] level_d, rise_d, fall_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= '0;
      s2      <= '0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      for (int i = 0; i < NUM_INS; i++) begin
        state_q[i] <= STABLE_LO;
        cnt_q[i]   <= '0;
      end
    end else begin
      s1      <= bus.io_in;
      s2      <= s1;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      for (int i = 0; i < NUM_INS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_INS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = '0;
      if (bus.db_bypass) begin
        state_d[i] = s2[i] ? STABLE_HI : STABLE_LO;
      end else begin
        case (state_q[i])
          STABLE_LO: if (s2[i]) begin
            state_d[i] = CHK_HI;
            cnt_d[i]   = CNT_ONE;
          end
          CHK_HI: begin
            if (!s2[i])                 state_d[i] = STABLE_LO;
            else if (cnt_q[i] == CNT_LAST) state_d[i] = STABLE_HI;
            else                        cnt_d[i]   = cnt_q[i] + CNT_ONE;
          end
          STABLE_HI: if (!s2[i]) begin
            state_d[i] = CHK_LO;
            cnt_d[i]   = CNT_ONE;
          end
          CHK_LO: begin
            if (s2[i])                  state_d[i] = STABLE_HI;
            else if (cnt_q[i] == CNT_LAST) state_d[i] = STABLE_LO;
            else                        cnt_d[i]   = cnt_q[i] + CNT_ONE;
          end
          default: state_d[i] = STABLE_LO;
        endcase
      end
    end
  end

  // Pulses derive from the level change itself, so rise and fall are mutually exclusive.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < NUM_INS; i++) begin
      if (bus.db_bypass)
        level_d[i] = s2[i];
      else if (state_q[i] == CHK_HI && s2[i] && cnt_q[i] == CNT_LAST)
        level_d[i] = 1'b1;
      else if (state_q[i] == CHK_LO && !s2[i] && cnt_q[i] == CNT_LAST)
        level_d[i] = 1'b0;
    end
    rise_d = level_d & ~level_q;
    fall_d = ~level_d & level_q;
  end

  assign bus.in_level = level_q;
  assign bus.in_rise  = rise_q;
  assign bus.in_fall  = fall_q;
endmodule

// File: tb/tb_upw_in_conditioner.sv
// Bench for upw_in_conditioner: directed sequences, vector table and randomized traffic
// against a sliding-window reference model.
module tb_upw_in_conditioner;
  localparam int N = 3;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  upw_in_conditioner_if #(.NUM_INS(N)) bus ();

  upw_in_conditioner #(.NUM_INS(N), .DEBOUNCE_CYCLES(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int rise_tot = 0;
  int fall_tot = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    rise_tot += $countones(bus.in_rise);
    fall_tot += $countones(bus.in_fall);
  endtask

  // Reference: a level flips once the last D synchronized samples all disagree with it.
  logic [N-1:0]        m_s1, m_s2, m_lvl, m_rise, m_fall;
  logic [N-1:0][D-1:0] m_hist;

  function automatic logic [N-1:0][D-1:0] shift_hist(input logic [N-1:0][D-1:0] h,
                                                      input logic [N-1:0] s);
    logic [N-1:0][D-1:0] r;
    for (int b = 0; b < N; b++) r[b] = {h[b][D-2:0], s[b]};
    return r;
  endfunction

  function automatic logic [N-1:0] next_lvl(input logic [N-1:0][D-1:0] h,
                                            input logic [N-1:0] lvl,
                                            input logic byp,
                                            input logic [N-1:0] s);
    logic [N-1:0] r;
    for (int b = 0; b < N; b++) begin
      if (byp)                       r[b] = s[b];
      else if (h[b] == {D{~lvl[b]}}) r[b] = ~lvl[b];
      else                           r[b] = lvl[b];
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 <= '0; m_s2 <= '0; m_lvl <= '0; m_rise <= '0; m_fall <= '0; m_hist <= '0;
    end else begin
      m_s1   <= bus.io_in;
      m_s2   <= m_s1;
      m_hist <= shift_hist(m_hist, m_s2);
      m_lvl  <= next_lvl(shift_hist(m_hist, m_s2), m_lvl, bus.db_bypass, m_s2);
      m_rise <= next_lvl(shift_hist(m_hist, m_s2), m_lvl, bus.db_bypass, m_s2) & ~m_lvl;
      m_fall <= ~next_lvl(shift_hist(m_hist, m_s2), m_lvl, bus.db_bypass, m_s2) & m_lvl;
    end
  end

  always @(negedge clk) begin
    check("model_level", bus.in_level, m_lvl);
    check("model_rise",  bus.in_rise,  m_rise);
    check("model_fall",  bus.in_fall,  m_fall);
    check("dual_pulse",  bus.in_rise & bus.in_fall, 0);
  end

  typedef struct {
    logic [N-1:0] io;
    logic         byp;
    int           cyc;
    logic [N-1:0] lvl;
    int           nr;
    int           nf;
  } vec_t;

  vec_t         tbl [10];
  logic         v [20];
  logic [5:0]   pat;

  initial begin
    tbl[0] = '{3'b000, 1'b0, 8, 3'b000, 0, 0};
    tbl[1] = '{3'b101, 1'b0, 8, 3'b101, 2, 0};
    tbl[2] = '{3'b111, 1'b0, 3, 3'b101, 0, 0};
    tbl[3] = '{3'b111, 1'b0, 5, 3'b111, 1, 0};
    tbl[4] = '{3'b000, 1'b1, 3, 3'b000, 0, 3};
    tbl[5] = '{3'b010, 1'b1, 2, 3'b000, 0, 0};
    tbl[6] = '{3'b010, 1'b1, 1, 3'b010, 1, 0};
    tbl[7] = '{3'b010, 1'b0, 6, 3'b010, 0, 0};
    tbl[8] = '{3'b000, 1'b0, 5, 3'b010, 0, 0};
    tbl[9] = '{3'b000, 1'b0, 1, 3'b000, 0, 1};

    bus.io_in = '0;
    bus.db_bypass = 1'b0;
    rst_n = 1'b0;
    repeat (3) step();
    check("reset_level", bus.in_level, 0);
    check("reset_rise",  bus.in_rise,  0);
    check("reset_fall",  bus.in_fall,  0);
    rst_n = 1'b1;

    // quiet after reset
    rise_tot = 0; fall_tot = 0;
    repeat (20) step();
    check("t1_level", bus.in_level, 0);
    check("t1_rises", rise_tot, 0);
    check("t1_falls", fall_tot, 0);

    // clean rise on bit 0 lands after edge D+2
    bus.io_in[0] = 1'b1;
    repeat (5) step();
    check("t2_level_early", bus.in_level[0], 0);
    step();
    check("t2_level", bus.in_level[0], 1);
    check("t2_rise",  bus.in_rise[0],  1);
    step();
    check("t2_rise_one_cycle", bus.in_rise[0], 0);

    // 3-cycle glitch on bit 1 rejected
    rise_tot = 0; fall_tot = 0;
    bus.io_in[1] = 1'b1;
    repeat (3) step();
    bus.io_in[1] = 1'b0;
    repeat (10) step();
    check("t3_level", bus.in_level[1], 0);
    check("t3_rises", rise_tot, 0);
    check("t3_falls", fall_tot, 0);

    // bounce 1,0,1,1,1,1 on bit 2
    pat = 6'b111101;
    for (int k = 0; k < 6; k++) begin
      bus.io_in[2] = pat[k];
      step();
    end
    step();
    check("t4_level_early", bus.in_level[2], 0);
    step();
    check("t4_level", bus.in_level[2], 1);
    check("t4_rise",  bus.in_rise[2],  1);
    bus.io_in[2] = 1'b0;
    repeat (5) step();
    check("t4_fall_early", bus.in_level[2], 1);
    step();
    check("t4_fall_level", bus.in_level[2], 0);
    check("t4_fall",       bus.in_fall[2],  1);
    step();
    check("t4_fall_one_cycle", bus.in_fall[2], 0);

    // bypass: 3-edge lag, pulse on every edge
    bus.db_bypass = 1'b1;
    for (int i = 0; i < 20; i++) begin
      v[i] = (i < 3) ? 1'b1 : ((((i - 3) / 2) % 2) == 0 ? 1'b0 : 1'b1);
      bus.io_in[0] = v[i];
      step();
      if (i >= 2) check("t5_level", bus.in_level[0], v[i-2]);
      if (i >= 3) begin
        check("t5_rise", bus.in_rise[0], v[i-2] & ~v[i-3]);
        check("t5_fall", bus.in_fall[0], ~v[i-2] & v[i-3]);
      end
    end
    bus.io_in[0] = 1'b1;
    repeat (3) step();
    bus.db_bypass = 1'b0;
    rise_tot = 0; fall_tot = 0;
    repeat (10) step();
    check("t5_exit_level", bus.in_level[0], 1);
    check("t5_exit_rises", rise_tot, 0);
    check("t5_exit_falls", fall_tot, 0);

    // async reset during CHK_HI of bit 0
    bus.io_in[2] = 1'b1;
    repeat (8) step();
    bus.io_in[0] = 1'b0;
    repeat (8) step();
    check("t6_pre_level", bus.in_level, 3'b100);
    bus.io_in[0] = 1'b1;
    repeat (4) step();
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_level", bus.in_level, 0);
    check("t6_async_rise",  bus.in_rise,  0);
    check("t6_async_fall",  bus.in_fall,  0);
    bus.io_in[2] = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    repeat (5) step();
    check("t6_level_early", bus.in_level[0], 0);
    step();
    check("t6_level", bus.in_level[0], 1);
    check("t6_rise",  bus.in_rise[0],  1);

    // randomized traffic, model checked every cycle
    for (int i = 0; i < 800; i++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 5) == 0) bus.io_in[b] = ~bus.io_in[b];
      if ($urandom_range(0, 59) == 0) bus.db_bypass = ~bus.db_bypass;
      step();
    end

    // vector table from a fresh reset
    bus.io_in = '0;
    bus.db_bypass = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int t = 0; t < 10; t++) begin
      bus.io_in = tbl[t].io;
      bus.db_bypass = tbl[t].byp;
      rise_tot = 0; fall_tot = 0;
      repeat (tbl[t].cyc) step();
      check($sformatf("tbl%0d_level", t), bus.in_level, tbl[t].lvl);
      check($sformatf("tbl%0d_rises", t), rise_tot, tbl[t].nr);
      check($sformatf("tbl%0d_falls", t), fall_tot, tbl[t].nf);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
    $fatal(1, "timeout");
  end
endmodule
